uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver and absorbs its AXI-Stream byte output. The UART receiver cannot stall the line, so this block always accepts input. It stores bytes with their frame/parity error tag in a first-word-fall-through FIFO. It drops and counts bytes that arrive when no space is free, and counts received error bytes for the status/register layer.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width; matches the receiver's Databits.
- ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  received byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  constant 1; input is never stalled.
- s_axis_error  in  1  framing/parity error tag for the byte.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO byte.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  consumer pop.
- m_axis_error  out  1  error tag of the head entry.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow_count  out  16  saturating count of bytes dropped while full.
- err_count  out  16  saturating count of input bytes with s_axis_error=1.
- clr_counts  in  1  synchronous clear of both counters.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) array holding {error, data}. wr_ptr, rd_ptr and count are registered; pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- push_req = s_axis_tvalid. pop = m_axis_tvalid & m_axis_tready.
- Write is accepted when push_req & (!full | pop). Full with a simultaneous pop therefore still accepts the write.
- Dropped write: push_req & full & !pop. The byte is discarded and overflow_count increments.
- count update: +1 on write only, −1 on pop only, unchanged on both or neither.
- m_axis_tdata and m_axis_error are a combinational read of mem[rd_ptr]. m_axis_tvalid = !empty.
- Output is undefined data when empty; consumers must qualify with tvalid.
- err_count increments on every s_axis_tvalid with s_axis_error=1, whether the byte was stored or dropped.
- Counters saturate at 16'hFFFF.
- clr_counts has priority over a same-cycle increment: the counter goes to 0 and that event is not counted.
- No state machine beyond the pointer/count datapath.

## Timing
- Reset: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, m_axis_tvalid=0, m_axis_error=0 (gated by empty), overflow_count=0, err_count=0, s_axis_tready=1. Array contents are not reset.
- Reset mid-operation flushes all entries on the next edge. A push or pop asserted in the reset cycle is ignored.
- Write latency: a byte accepted at edge N is visible on m_axis_* with m_axis_tvalid=1 immediately after edge N, i.e. usable in cycle N+1.
- Pop: the head advances at the edge where m_axis_tvalid & m_axis_tready. The next entry appears combinationally after that edge.
- Empty with a simultaneous push and tready: no pop occurs (tvalid=0). The byte is stored and count becomes 1.
- Counter updates are visible the cycle after the event.

## Configuration
- UART_RX_FIFO_DROP_ERR_EN defined:
  - Bytes with s_axis_error=1 are never written and never counted in overflow_count, even when the FIFO is full.
  - They still increment err_count.
  - m_axis_error is driven constant 0, and the error bit is not stored (array width DATA_WIDTH).
- UART_RX_FIFO_DROP_ERR_EN undefined: error bytes are stored and forwarded with m_axis_error=1, as described above.

## Test plan
- Reset, then push 8'hA5 (error=0) with m_axis_tready=0 -> next cycle m_axis_tvalid=1, m_axis_tdata=8'hA5, count=1, empty=0.
- Push 8'h00..8'h0F back-to-back with tready=0 (depth 16) -> full=1, count=16. A 17th push 8'h55 -> dropped, overflow_count=1, count stays 16. Draining yields 8'h00..8'h0F in order.
- With the FIFO full, push 8'h77 and pop in the same cycle -> write accepted, overflow_count unchanged, count stays 16, 8'h77 is last out.
- Push 8'h3C with error=1 -> err_count=1, and m_axis_error=1 at head (macro undefined) or FIFO stays empty (macro defined).
- Force overflow_count to 16'hFFFF via repeated overflows, drop once more -> stays 16'hFFFF. Assert clr_counts coincident with a drop -> 0.
- Fill 5 entries, assert rst for one cycle with push and pop active -> count=0, empty=1, m_axis_tvalid=0, counters 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver; input is never stalled, overflow bytes are dropped and counted.
// Build option: define UART_RX_FIFO_DROP_ERR_EN to discard error-tagged bytes instead of storing them.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_error,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_error,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           overflow_count,
    output logic [15:0]           err_count,
    input  logic                  clr_counts
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam int ENTRY_W = DATA_WIDTH;
`else
    localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [15:0]           ovf_q, ovf_d;
    logic [15:0]           err_q, err_d;

    logic                  push_req;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;
    logic                  err_evt;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head_entry;

    assign s_axis_tready = 1'b1;
    assign full          = (count_q == FULL_COUNT);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign overflow_count = ovf_q;
    assign err_count     = err_q;

    // Error-tagged bytes are filtered before the FIFO when the drop option is built in,
    // so they can neither occupy an entry nor register as an overflow.
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign push_req = s_axis_tvalid & ~s_axis_error;
    assign wr_entry = s_axis_tdata;
`else
    assign push_req = s_axis_tvalid;
    assign wr_entry = {s_axis_error, s_axis_tdata};
`endif

    assign pop     = ~empty & m_axis_tready;
    assign wr_en   = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;
    assign err_evt = s_axis_tvalid & s_axis_error;

    assign head_entry    = mem_q[rd_ptr_q];
    assign m_axis_tdata  = head_entry[DATA_WIDTH-1:0];
    assign m_axis_tvalid = ~empty;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign m_axis_error  = 1'b0;
`else
    assign m_axis_error  = head_entry[DATA_WIDTH] & ~empty;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        if (wr_en && !pop) begin
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end

        // A clear wins over a coincident event, which is then lost rather than counted.
        if (clr_counts) begin
            ovf_d = '0;
            err_d = '0;
        end else begin
            if (drop && ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
            if (err_evt && err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_error;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_error;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] overflow_count;
    logic [15:0] err_count;
    logic        clr_counts;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_error(s_axis_error),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_error(m_axis_error),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow_count(overflow_count),
        .err_count(err_count),
        .clr_counts(clr_counts)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic rdy);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_error  = e;
        m_axis_tready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_counts = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++;
        if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); else pass_cnt++;
        total_cnt++;
        if (m_axis_tvalid !== 1'b0 || m_axis_error !== 1'b0) $display("FAIL reset_out: tvalid=%b error=%b want 0/0", m_axis_tvalid, m_axis_error); else pass_cnt++;
        total_cnt++;
        if (overflow_count !== 16'd0 || err_count !== 16'd0) $display("FAIL reset_counters: ovf=%h err=%h want 0/0", overflow_count, err_count); else pass_cnt++;
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", s_axis_tready); else pass_cnt++;
    endtask

    task automatic test_single_push();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA5) $display("FAIL single_head: tvalid=%b data=%h want 1/a5", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
        total_cnt++;
        if (count !== 5'd1 || empty !== 1'b0) $display("FAIL single_count: count=%0d empty=%b want 1/0", count, empty); else pass_cnt++;
        total_cnt++;
        if (m_axis_error !== 1'b0) $display("FAIL single_error: got %b want 0", m_axis_error); else pass_cnt++;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        total_cnt++;
        if (empty !== 1'b1 || count !== 5'd0) $display("FAIL single_pop: empty=%b count=%0d want 1/0", empty, count); else pass_cnt++;
    endtask

    task automatic test_empty_push_ready();
        drive(1'b1, 8'h5A, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (count !== 5'd1 || m_axis_tdata !== 8'h5A) $display("FAIL empty_push_ready: count=%0d data=%h want 1/5a", count, m_axis_tdata); else pass_cnt++;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (full !== 1'b1 || count !== 5'd16) $display("FAIL fill_full: full=%b count=%0d want 1/16", full, count); else pass_cnt++;
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (overflow_count !== 16'd1 || count !== 5'd16) $display("FAIL overflow_drop: ovf=%0d count=%0d want 1/16", overflow_count, count); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(i)) $display("FAIL drain_order[%0d]: tvalid=%b data=%h want 1/%h", i, m_axis_tvalid, m_axis_tdata, 8'(i)); else pass_cnt++;
            m_axis_tready = 1'b1;
            step();
        end
        m_axis_tready = 1'b0;
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL drain_empty: empty=%b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (count !== 5'd16 || overflow_count !== 16'd1) $display("FAIL full_push_pop: count=%0d ovf=%0d want 16/1", count, overflow_count); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h77 : (8'h11 + 8'(i));
            total_cnt++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) $display("FAIL full_pp_order[%0d]: tvalid=%b data=%h want 1/%h", i, m_axis_tvalid, m_axis_tdata, exp); else pass_cnt++;
            m_axis_tready = 1'b1;
            step();
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_error_byte();
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (err_count !== 16'd1) $display("FAIL err_count: got %0d want 1", err_count); else pass_cnt++;
`ifdef UART_RX_FIFO_DROP_ERR_EN
        total_cnt++;
        if (empty !== 1'b1 || m_axis_error !== 1'b0) $display("FAIL err_dropped: empty=%b error=%b want 1/0", empty, m_axis_error); else pass_cnt++;
`else
        total_cnt++;
        if (m_axis_tvalid !== 1'b1 || m_axis_error !== 1'b1 || m_axis_tdata !== 8'h3C) $display("FAIL err_stored: tvalid=%b error=%b data=%h want 1/1/3c", m_axis_tvalid, m_axis_error, m_axis_tdata); else pass_cnt++;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
`endif
        total_cnt++;
        if (overflow_count !== 16'd1) $display("FAIL err_no_ovf: ovf=%0d want 1", overflow_count); else pass_cnt++;
    endtask

    task automatic test_saturate_clear();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        repeat (65534) step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (overflow_count !== 16'hFFFF) $display("FAIL ovf_reach_max: got %h want ffff", overflow_count); else pass_cnt++;
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (overflow_count !== 16'hFFFF) $display("FAIL ovf_saturate: got %h want ffff", overflow_count); else pass_cnt++;
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        clr_counts = 1'b1;
        step();
        clr_counts = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (overflow_count !== 16'd0 || err_count !== 16'd0) $display("FAIL clr_priority: ovf=%h err=%h want 0/0", overflow_count, err_count); else pass_cnt++;
        total_cnt++;
        if (count !== 5'd16) $display("FAIL clr_keeps_data: count=%0d want 16", count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (count !== 5'd5 || err_count !== 16'd1) $display("FAIL pre_reset: count=%0d err=%0d want 5/1", count, err_count); else pass_cnt++;
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total_cnt++;
        if (count !== 5'd0 || empty !== 1'b1 || m_axis_tvalid !== 1'b0) $display("FAIL mid_reset_flush: count=%0d empty=%b tvalid=%b want 0/1/0", count, empty, m_axis_tvalid); else pass_cnt++;
        total_cnt++;
        if (overflow_count !== 16'd0 || err_count !== 16'd0) $display("FAIL mid_reset_counters: ovf=%h err=%h want 0/0", overflow_count, err_count); else pass_cnt++;
        step();
        total_cnt++;
        if (empty !== 1'b1 || m_axis_error !== 1'b0) $display("FAIL post_reset_idle: empty=%b error=%b want 1/0", empty, m_axis_error); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_empty_push_ready();
        test_fill_overflow();
        test_full_push_pop();
        test_error_byte();
        test_saturate_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
